// File: rtl/mem_access_stage.sv
// MEM stage of the 5-stage MIPS pipeline: data-memory access over a request/ready bus,
// branch resolution, and the MEM/WB pipeline register. Stalls upstream while an access is in flight.
module mem_access_stage #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        regwrite_in,
  input  logic        memtoreg_in,
  input  logic        memwrite_in,
  input  logic        memread_in,
  input  logic        branch_in,
  input  logic [31:0] branch_addr_in,
  input  logic        zero_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] write_data_in,
  input  logic [4:0]  write_reg_in,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ready,
  output logic        stall_out,
  output logic        pc_src,
  output logic [31:0] branch_target,
  output logic        flush_out,
  output logic        regwrite_out,
  output logic        memtoreg_out,
  output logic [31:0] read_data_out,
  output logic [31:0] alu_result_out,
  output logic [4:0]  write_reg_out,
  output logic        misalign_err,
  output logic        timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_abort;
  logic [31:0]       r_buf;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic [31:0]       r_dmem_addr;
  logic [31:0]       r_dmem_wdata;

  logic w_mem_op;
  logic w_misaligned;
  logic w_launch;
  logic w_timeout_hit;

  assign w_mem_op      = memread_in | memwrite_in;
  assign w_misaligned  = w_mem_op & (alu_result_in[1:0] != 2'b00);
  assign w_launch      = (r_state == S_IDLE) & w_mem_op & ~w_misaligned;
  assign w_timeout_hit = (r_state == S_WAIT) & ~dmem_ready & (r_cnt == CNT_W'(MAX_WAIT - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_launch) w_state_next = S_WAIT;
      S_WAIT:  if (dmem_ready || w_timeout_hit) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    stall_out     = ~reset & (w_launch | (r_state == S_WAIT));
    pc_src        = branch_in & zero_in & ~stall_out & ~reset;
    flush_out     = pc_src;
    branch_target = reset ? 32'd0 : branch_addr_in;
  end

  // Bus side: request fields are launched from IDLE and held stable until ready or abort.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= 32'd0;
      r_dmem_wdata <= 32'd0;
      r_cnt        <= '0;
      r_abort      <= 1'b0;
      r_buf        <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_launch) begin
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= memwrite_in;
            r_dmem_addr  <= alu_result_in;
            r_dmem_wdata <= write_data_in;
            r_cnt        <= '0;
            r_buf        <= 32'd0;
          end
        end
        S_WAIT: begin
          if (dmem_ready) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            if (!r_dmem_we) r_buf <= dmem_rdata;
          end else if (w_timeout_hit) begin
            r_dmem_req <= 1'b0;
            r_dmem_we  <= 1'b0;
            r_buf      <= 32'd0;
            r_abort    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DONE:  r_abort <= 1'b0;
        default: r_abort <= 1'b0;
      endcase
    end
  end

  assign dmem_req   = r_dmem_req;
  assign dmem_we    = r_dmem_we;
  assign dmem_addr  = r_dmem_addr;
  assign dmem_wdata = r_dmem_wdata;

  // MEM/WB register: a stall cycle inserts a bubble while data fields hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      regwrite_out   <= 1'b0;
      memtoreg_out   <= 1'b0;
      read_data_out  <= 32'd0;
      alu_result_out <= 32'd0;
      write_reg_out  <= 5'd0;
      misalign_err   <= 1'b0;
      timeout_err    <= 1'b0;
    end else if (stall_out) begin
      regwrite_out <= 1'b0;
      memtoreg_out <= 1'b0;
      misalign_err <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      memtoreg_out   <= memtoreg_in;
      alu_result_out <= alu_result_in;
      write_reg_out  <= write_reg_in;
      read_data_out  <= (r_state == S_DONE) ? r_buf : 32'd0;
      regwrite_out   <= regwrite_in & ~w_misaligned & ~r_abort;
      misalign_err   <= w_misaligned;
      timeout_err    <= (r_state == S_DONE) & r_abort;
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized ops
// checked against a transaction-level latency/result model.
module tb_mem_access_stage;

  localparam int MAXW = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        regwrite_in, memtoreg_in, memwrite_in, memread_in, branch_in, zero_in;
  logic [31:0] branch_addr_in, alu_result_in, write_data_in, dmem_rdata;
  logic [4:0]  write_reg_in;
  logic        dmem_ready;
  logic        dmem_req, dmem_we, stall_out, pc_src, flush_out;
  logic [31:0] dmem_addr, dmem_wdata, branch_target, read_data_out, alu_result_out;
  logic        regwrite_out, memtoreg_out, misalign_err, timeout_err;
  logic [4:0]  write_reg_out;

  int checks = 0;
  int errors = 0;

  mem_access_stage #(.MAX_WAIT(MAXW), .CNT_W(8)) dut (
    .clk(clk), .reset(reset),
    .regwrite_in(regwrite_in), .memtoreg_in(memtoreg_in), .memwrite_in(memwrite_in),
    .memread_in(memread_in), .branch_in(branch_in), .branch_addr_in(branch_addr_in),
    .zero_in(zero_in), .alu_result_in(alu_result_in), .write_data_in(write_data_in),
    .write_reg_in(write_reg_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
    .stall_out(stall_out), .pc_src(pc_src), .branch_target(branch_target), .flush_out(flush_out),
    .regwrite_out(regwrite_out), .memtoreg_out(memtoreg_out), .read_data_out(read_data_out),
    .alu_result_out(alu_result_out), .write_reg_out(write_reg_out),
    .misalign_err(misalign_err), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rw, mt, mw, mr;
    logic [31:0] addr, wd, rdata;
    logic [4:0]  wreg;
  } op_t;

  typedef struct packed {
    logic [7:0]  nst;
    logic [7:0]  nreq;
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        stable;
    logic        regwrite;
    logic        memtoreg;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic        mis;
    logic        tmo;
  } obs_t;

  // Reference: an aligned memory op stalls one launch cycle plus min(lat, MAXW) bus cycles.
  function automatic obs_t model(input op_t op, input int lat);
    obs_t e;
    bit   mem, mis, tmo;
    int   n;
    e = '0;
    e.stable = 1'b1;
    mem = op.mr || op.mw;
    mis = mem && (op.addr % 4 != 0);
    e.memtoreg = op.mt;
    e.alu = op.addr;
    e.wreg = op.wreg;
    if (!mem || mis) begin
      e.regwrite = op.rw && !mis;
      e.mis = mis;
    end else begin
      tmo = lat > MAXW;
      n = tmo ? MAXW : lat;
      e.nst = 8'(n + 1);
      e.nreq = 8'(n);
      e.addr = op.addr;
      e.we = op.mw;
      e.wdata = op.wd;
      e.regwrite = op.rw && !tmo;
      e.rdata = (!op.mw && !tmo) ? op.rdata : 32'd0;
      e.tmo = tmo;
    end
    return e;
  endfunction

  function automatic op_t mk(input bit rw, mt, mw, mr, input logic [31:0] addr, wd, rd,
                             input logic [4:0] wreg);
    op_t op;
    op.rw = rw; op.mt = mt; op.mw = mw; op.mr = mr;
    op.addr = addr; op.wd = wd; op.rdata = rd; op.wreg = wreg;
    return op;
  endfunction

  task automatic set_nop();
    regwrite_in = 0; memtoreg_in = 0; memwrite_in = 0; memread_in = 0;
    branch_in = 0; zero_in = 0; branch_addr_in = 0; alu_result_in = 0;
    write_data_in = 0; write_reg_in = 0; dmem_rdata = 0; dmem_ready = 0;
  endtask

  // Presents one op from posedge+1, holds it while stalled, answers the bus after lat request cycles.
  task automatic do_op(input op_t op, input int lat, output obs_t o);
    bit done = 0;
    o = '0;
    o.stable = 1'b1;
    regwrite_in = op.rw; memtoreg_in = op.mt; memwrite_in = op.mw; memread_in = op.mr;
    alu_result_in = op.addr; write_data_in = op.wd; write_reg_in = op.wreg;
    dmem_rdata = op.rdata; dmem_ready = 0;
    for (int c = 0; c < 64 && !done; c++) begin
      #1;
      if (dmem_req) begin
        if (o.nreq == 0) begin
          o.addr = dmem_addr; o.we = dmem_we; o.wdata = dmem_wdata;
        end else if (dmem_addr !== o.addr || dmem_we !== o.we || dmem_wdata !== o.wdata) begin
          o.stable = 1'b0;
        end
        o.nreq = o.nreq + 8'd1;
      end
      if (o.nst != 0 && (regwrite_out || memtoreg_out || misalign_err || timeout_err))
        o.stable = 1'b0;
      if (!stall_out) begin
        done = 1;
        dmem_ready = 1'($urandom_range(0, 1));
      end else begin
        o.nst = o.nst + 8'd1;
        dmem_ready = dmem_req && (int'(o.nreq) == lat);
      end
      @(posedge clk);
      #1;
      dmem_ready = 0;
      dmem_rdata = op.rdata;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL op_bound stall never released after 64 cycles, required release");
    end
    o.regwrite = regwrite_out; o.memtoreg = memtoreg_out; o.rdata = read_data_out;
    o.alu = alu_result_out; o.wreg = write_reg_out; o.mis = misalign_err; o.tmo = timeout_err;
  endtask

  task automatic test_reset();
    set_nop();
    reset = 1;
    branch_in = 1; zero_in = 1; branch_addr_in = 32'h40; memread_in = 1; alu_result_in = 32'h100;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({stall_out, pc_src, flush_out, branch_target} !== 35'd0) begin
      errors++;
      $display("FAIL reset_comb stall/pc_src/flush/target=%h required 0",
               {stall_out, pc_src, flush_out, branch_target});
    end
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_wdata, regwrite_out, memtoreg_out, read_data_out,
         alu_result_out, write_reg_out, misalign_err, timeout_err} !== '0) begin
      errors++;
      $display("FAIL reset_regs registered outputs not all 0 (req=%b rw=%b alu=%h)",
               dmem_req, regwrite_out, alu_result_out);
    end
    set_nop();
    reset = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_load();
    obs_t o, e;
    op_t  op;
    op = mk(1, 1, 0, 1, 32'h100, 32'h0, 32'hDEADBEEF, 5'd5);
    do_op(op, 1, o);
    checks++;
    if (o.nst !== 8'd2 || o.nreq !== 8'd1 || o.addr !== 32'h100 || o.we !== 1'b0) begin
      errors++;
      $display("FAIL load_bus stall=%0d req=%0d addr=%h we=%b required 2 1 00000100 0",
               o.nst, o.nreq, o.addr, o.we);
    end
    checks++;
    if (o.rdata !== 32'hDEADBEEF || o.regwrite !== 1'b1 || o.memtoreg !== 1'b1) begin
      errors++;
      $display("FAIL load_wb rdata=%h rw=%b mt=%b required deadbeef 1 1", o.rdata, o.regwrite, o.memtoreg);
    end
    e = model(op, 1);
    checks++;
    if (o !== e) begin
      errors++;
      $display("FAIL load_model got %h required %h", o, e);
    end
  endtask

  task automatic test_store();
    obs_t o;
    do_op(mk(0, 0, 1, 0, 32'h204, 32'h12345678, 32'hCAFEF00D, 5'd0), 4, o);
    checks++;
    if (o.nst !== 8'd5 || o.nreq !== 8'd4 || o.we !== 1'b1 || o.addr !== 32'h204 ||
        o.wdata !== 32'h12345678 || o.stable !== 1'b1) begin
      errors++;
      $display("FAIL store_bus stall=%0d req=%0d we=%b addr=%h wdata=%h stable=%b required 5 4 1 204 12345678 1",
               o.nst, o.nreq, o.we, o.addr, o.wdata, o.stable);
    end
    checks++;
    if (o.regwrite !== 1'b0 || o.tmo !== 1'b0) begin
      errors++;
      $display("FAIL store_wb regwrite=%b timeout=%b required 0 0", o.regwrite, o.tmo);
    end
  endtask

  task automatic test_branch();
    set_nop();
    branch_in = 1; zero_in = 1; branch_addr_in = 32'h40;
    #1;
    checks++;
    if ({pc_src, flush_out, branch_target, stall_out} !== {1'b1, 1'b1, 32'h40, 1'b0}) begin
      errors++;
      $display("FAIL branch_taken pc_src=%b flush=%b target=%h stall=%b required 1 1 40 0",
               pc_src, flush_out, branch_target, stall_out);
    end
    zero_in = 0;
    #1;
    checks++;
    if ({pc_src, flush_out} !== 2'b00) begin
      errors++;
      $display("FAIL branch_not_taken pc_src=%b flush=%b required 0 0", pc_src, flush_out);
    end
    @(posedge clk);
    #1;
    set_nop();
  endtask

  task automatic test_misaligned();
    obs_t o;
    do_op(mk(1, 1, 0, 1, 32'h102, 32'h0, 32'h11111111, 5'd7), 1, o);
    checks++;
    if (o.nst !== 8'd0 || o.nreq !== 8'd0 || o.mis !== 1'b1 || o.regwrite !== 1'b0) begin
      errors++;
      $display("FAIL misalign stall=%0d req=%0d err=%b rw=%b required 0 0 1 0",
               o.nst, o.nreq, o.mis, o.regwrite);
    end
    do_op(mk(0, 0, 0, 0, 32'h8, 32'h0, 32'h0, 5'd1), 1, o);
    checks++;
    if (o.mis !== 1'b0) begin
      errors++;
      $display("FAIL misalign_pulse err=%b on following op required 0", o.mis);
    end
  endtask

  task automatic test_timeout();
    obs_t o;
    do_op(mk(1, 1, 0, 1, 32'h300, 32'h0, 32'h77777777, 5'd9), 1000, o);
    checks++;
    if (o.nreq !== 8'd4 || o.nst !== 8'd5 || o.tmo !== 1'b1 || o.rdata !== 32'd0 || o.regwrite !== 1'b0) begin
      errors++;
      $display("FAIL timeout req=%0d stall=%0d err=%b rdata=%h rw=%b required 4 5 1 0 0",
               o.nreq, o.nst, o.tmo, o.rdata, o.regwrite);
    end
    do_op(mk(1, 0, 0, 0, 32'h55, 32'h0, 32'h0, 5'd3), 1, o);
    checks++;
    if (o.regwrite !== 1'b1 || o.tmo !== 1'b0 || o.alu !== 32'h55) begin
      errors++;
      $display("FAIL timeout_after rw=%b err=%b alu=%h required 1 0 55", o.regwrite, o.tmo, o.alu);
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    do_op(mk(1, 0, 0, 0, 32'h1234, 32'h0, 32'h0, 5'd4), 1, o);
    memread_in = 1; alu_result_in = 32'h400; write_reg_in = 5'd6; regwrite_in = 1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dmem_req !== 1'b1 || stall_out !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_pre req=%b stall=%b required 1 1", dmem_req, stall_out);
    end
    reset = 1;
    @(posedge clk);
    #1;
    checks++;
    if ({dmem_req, dmem_we, dmem_addr, regwrite_out, alu_result_out, write_reg_out,
         stall_out, pc_src} !== '0) begin
      errors++;
      $display("FAIL mid_reset req=%b addr=%h alu=%h stall=%b required all 0",
               dmem_req, dmem_addr, alu_result_out, stall_out);
    end
    set_nop();
    reset = 0;
    @(posedge clk);
    #1;
    dmem_ready = 1; dmem_rdata = 32'hAAAA5555;
    @(posedge clk);
    #1;
    dmem_ready = 0;
    @(posedge clk);
    #1;
    checks++;
    if (read_data_out !== 32'd0 || regwrite_out !== 1'b0 || dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_ready rdata=%h rw=%b req=%b stall=%b required 0 0 0 0",
               read_data_out, regwrite_out, dmem_req, stall_out);
    end
  endtask

  task automatic test_random();
    obs_t o, e;
    op_t  op;
    int   lat;
    for (int i = 0; i < 40; i++) begin
      int kind = $urandom_range(0, 4);
      op = mk(1'($urandom), 1'($urandom), 0, 0, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
              5'($urandom));
      case (kind)
        1: op.mr = 1;
        2: op.mw = 1;
        3: begin op.mr = 1; op.mw = 1; end
        4: begin op.mr = 1; op.addr = op.addr | 32'($urandom_range(1, 3)); end
        default: ;
      endcase
      lat = $urandom_range(1, MAXW + 1);
      do_op(op, lat, o);
      e = model(op, lat);
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL random_op%0d kind=%0d lat=%0d got %h required %h", i, kind, lat, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_branch();
    test_misaligned();
    test_timeout();
    test_reset_mid_access();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Consumes the EX/MEM pipeline register outputs and performs loads and stores over a variable-latency data-memory request/ready bus.
- Resolves branches (PCSrc, target, flush) and contains the MEM/WB pipeline register feeding writeback.
- Stalls upstream stages while a memory access is outstanding.
- Flags misaligned accesses and bus timeouts.

Parameters:
- MAX_WAIT, 15: maximum cycles in WAIT without dmem_ready before the access is aborted. Range 1..255.
- CNT_W, 8: width of the wait counter.

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- regwrite_in, memtoreg_in, memwrite_in, memread_in, branch_in  in  1 each  control from EX/MEM
- branch_addr_in  in  32  branch target from EX/MEM
- zero_in  in  1  ALU zero flag
- alu_result_in  in  32  ALU result / memory address
- write_data_in  in  32  store data
- write_reg_in  in  5  destination register
- dmem_req  out  1  memory request, registered
- dmem_we  out  1  1 = store, registered
- dmem_addr  out  32  word address, registered
- dmem_wdata  out  32  store data, registered
- dmem_rdata  in  32  load data, valid when dmem_ready=1
- dmem_ready  in  1  access complete
- stall_out  out  1  hold PC, IF/ID, ID/EX, EX/MEM (combinational)
- pc_src  out  1  take branch (combinational)
- branch_target  out  32  equals branch_addr_in
- flush_out  out  1  flush IF/ID, ID/EX, EX/MEM; equals pc_src
- regwrite_out, memtoreg_out  out  1 each  MEM/WB control
- read_data_out  out  32  MEM/WB load data
- alu_result_out  out  32  MEM/WB ALU result
- write_reg_out  out  5  MEM/WB destination
- misalign_err  out  1  one-cycle error pulse, registered
- timeout_err  out  1  one-cycle error pulse, registered

Behaviour:
- Decode:
  - mem_op = memread_in | memwrite_in.
  - misaligned = mem_op & (alu_result_in[1:0] != 0).
  - If memread_in and memwrite_in are both set, treat the op as a store.
- FSM states IDLE, WAIT, DONE. Reset state IDLE; wait counter 0.
- IDLE:
  - mem_op & !misaligned: stall_out=1. At the edge, register dmem_req=1, dmem_we=memwrite_in, dmem_addr=alu_result_in, dmem_wdata=write_data_in; go to WAIT; counter=0.
  - Otherwise: stall_out=0, no bus activity.
- WAIT:
  - stall_out=1; dmem_req held high with stable addr/we/wdata.
  - dmem_ready=1: capture dmem_rdata (loads) into an internal buffer; dmem_req=0 at the edge; go to DONE.
  - dmem_ready=0 and counter==MAX_WAIT-1: abort. dmem_req=0, buffer=0, set abort flag, go to DONE.
  - Otherwise: counter+1.
- DONE:
  - stall_out=0, so EX/MEM advances at this edge. No new request is evaluated this cycle. Go to IDLE.
- stall_out = (IDLE & mem_op & !misaligned) | WAIT, forced 0 while reset=1.
- Branch: pc_src = branch_in & zero_in & !stall_out & !reset; flush_out = pc_src; branch_target = branch_addr_in.
- MEM/WB register, updated every edge:
  - When stall_out=1: insert a bubble. regwrite_out=0, memtoreg_out=0, misalign_err=0, timeout_err=0; data fields hold.
  - When stall_out=0: memtoreg_out<=memtoreg_in; alu_result_out<=alu_result_in; write_reg_out<=write_reg_in.
  - read_data_out <= buffer when in DONE, else 0.
  - regwrite_out <= regwrite_in & !misaligned & !abort.
  - misalign_err <= misaligned; timeout_err <= (DONE & abort).
  - Abort flag clears on leaving DONE.
- Latency:
  - Non-memory and misaligned ops: 1 cycle through MEM/WB.
  - Memory op: stall for 1 + N cycles (N = WAIT cycles, N>=1). MEM/WB loads at the end of the DONE cycle. Minimum total is 3 cycles.
- Misaligned op: no bus request, no stall, register write suppressed, misalign_err pulses with the MEM/WB load.
- Reset, including mid-access: at the next edge state=IDLE, dmem_req=0 and all registered outputs are 0. Registered outputs are dmem_*, regwrite_out, memtoreg_out, read_data_out, alu_result_out, write_reg_out, misalign_err, timeout_err. Combinational outputs are forced 0 while reset=1. No ready response is consumed after reset.
- dmem_ready while not in WAIT is ignored.

Test Plan:
- Load, ready on first WAIT cycle: lw addr 0x100, dmem_rdata=0xDEADBEEF -> stall high 2 cycles; dmem_req high 1 cycle with addr 0x100, we=0; after DONE, read_data_out=0xDEADBEEF, regwrite_out=1, memtoreg_out=1.
- Store, ready after 4 cycles: sw addr 0x204, data 0x12345678 -> dmem_req/we high 4 cycles with stable addr/wdata; stall 5 cycles; MEM/WB regwrite_out=0 throughout.
- Branch: branch_in=1, zero_in=1, branch_addr_in=0x40 -> same-cycle pc_src=1, flush_out=1, branch_target=0x40, no stall. With zero_in=0 -> pc_src=0.
- Misaligned lw at 0x102 -> no dmem_req, no stall; next cycle misalign_err=1 for 1 cycle, regwrite_out=0.
- Timeout with MAX_WAIT=4, dmem_ready tied 0: dmem_req high exactly 4 cycles, then DONE; timeout_err=1 for 1 cycle, read_data_out=0, regwrite_out=0. Then a following add with regwrite_in=1 -> regwrite_out=1 next cycle.
- Reset asserted in WAIT cycle 2 -> next edge dmem_req=0, state IDLE, all outputs 0. A later dmem_ready pulse produces no MEM/WB update.
